// File: rtl/uart_pkg.sv
// Shared UART receive definitions: baud table, divider helper, FSM states and parity modes.
// Everything here is elaboration-time data; nothing in this file creates hardware by itself.
// Included first so the sampler and the top both see one definition of each item.
package uart_pkg;

  localparam int unsigned BAUD_NUM = 5;
  // Index is the Baud_set code; codes beyond the table fall back to entry 0.
  localparam int unsigned BAUD_TAB [BAUD_NUM] = '{115200, 57600, 38400, 19200, 9600};

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Clocks per bit, rounded to nearest: 50 MHz gives 434, 868, 1302, 2604, 5208.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [2:0] sel);
    int unsigned baud;
    baud = (sel < 3'(BAUD_NUM)) ? BAUD_TAB[sel] : BAUD_TAB[0];
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Per-bit timing: counter 0..bit_div-1 with a 3-vote majority around the bit centre.
// sample_valid/bit_val resolve in the cycle of the third vote; bit_end marks the last count.
// No backpressure: the counter free-runs and is restarted by clear_i on every state entry.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W = 13
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] bit_div_i,
  input  logic             rx_i,
  output logic             sample_valid,
  output logic             bit_val,
  output logic             bit_end
);

  logic [CNT_W-1:0] cnt_q, cnt_d, half;
  logic             s0_q, s1_q, maj_q, maj_now;

  assign half         = bit_div_i >> 1;
  assign bit_end      = (cnt_q == bit_div_i - CNT_W'(1));
  assign sample_valid = (cnt_q == half + CNT_W'(1));
  // Third vote is the live line value, so the majority is ready in the same cycle.
  assign maj_now      = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);
  // Outside the vote cycle the held majority is presented (used at bit_end).
  assign bit_val      = sample_valid ? maj_now : maj_q;

  // Counter restarts on state entry and wraps at each bit boundary.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || bit_end) cnt_d = '0;
  end

  // Counter register, first two votes and the held majority.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      s0_q  <= 1'b0;
      s1_q  <= 1'b0;
      maj_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_q == half - CNT_W'(1)) s0_q <= rx_i;
      if (cnt_q == half)             s1_q <= rx_i;
      if (sample_valid)              maj_q <= maj_now;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: sync, start detect, data/parity/stop with majority sampling.
// rx_done pulses one cycle after the last stop bit's third vote (mid stop bit), not at bit end.
// No backpressure: Data and the error flags hold until overwritten by the next rx_done.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic [2:0]        Baud_set,
  input  logic              uart_rx,
  output logic [DATA_W-1:0] Data,
  output logic              rx_done,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int unsigned DIV_MAX = baud_div(CLK_FREQ, 3'd4);
  localparam int unsigned CNT_W   = $clog2(DIV_MAX + 1);
  localparam int unsigned BIT_CW  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] DIV_0 = CNT_W'(baud_div(CLK_FREQ, 3'd0));
  localparam logic [CNT_W-1:0] DIV_1 = CNT_W'(baud_div(CLK_FREQ, 3'd1));
  localparam logic [CNT_W-1:0] DIV_2 = CNT_W'(baud_div(CLK_FREQ, 3'd2));
  localparam logic [CNT_W-1:0] DIV_3 = CNT_W'(baud_div(CLK_FREQ, 3'd3));
  localparam logic [CNT_W-1:0] DIV_4 = CNT_W'(baud_div(CLK_FREQ, 3'd4));
  localparam logic PAR_INV = (PARITY == PAR_ODD);

  logic              sync1_q, sync2_q, prev_q, fall;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  div_q, div_d, sel_div;
  logic [BIT_CW-1:0] bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
  logic              perr_acc_q, perr_acc_d, ferr_acc_q, ferr_acc_d;
  logic              perr_q, perr_d, ferr_q, ferr_d, done_q, done_d;
  logic              clear, sample_valid, bit_val, bit_end, last_stop;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall = prev_q & ~sync2_q;

  // Decode the baud code into clocks per bit; sampled only at frame start.
  always_comb begin
    sel_div = DIV_0;
    case (Baud_set)
      3'd1:    sel_div = DIV_1;
      3'd2:    sel_div = DIV_2;
      3'd3:    sel_div = DIV_3;
      3'd4:    sel_div = DIV_4;
      default: sel_div = DIV_0;
    endcase
  end

  // Counter held at zero while idle and restarted whenever the state changes.
  assign clear     = (state_q == ST_IDLE) || (state_d != state_q);
  assign last_stop = (STOP_BITS == 1) || (stop_cnt_q == 1'b1);

  uart_bit_sampler #(.CNT_W(CNT_W)) u_sampler (
    .sysclk       (sysclk),
    .rst          (rst),
    .clear_i      (clear),
    .bit_div_i    (div_q),
    .rx_i         (sync2_q),
    .sample_valid (sample_valid),
    .bit_val      (bit_val),
    .bit_end      (bit_end)
  );

  // Frame FSM: next state, shift/accumulate, and result loading.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          div_d   = sel_div;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = bit_val ? ST_IDLE : ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {bit_val, shift_q[DATA_W-1:1]};
          if (bit_cnt_q == BIT_CW'(DATA_W - 1)) begin
            state_d    = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          perr_acc_d = bit_val ^ (^shift_q) ^ PAR_INV;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (last_stop) begin
          // Final stop bit is judged at its third vote so the next start edge is not missed.
          if (sample_valid) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            data_d  = shift_q;
            perr_d  = perr_acc_q;
            ferr_d  = ferr_acc_q | ~bit_val;
          end
        end else if (bit_end) begin
          ferr_acc_d = ferr_acc_q | ~bit_val;
          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      div_q      <= DIV_0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
    end
  end

  assign Data       = data_q;
  assign rx_done    = done_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: one no-parity receiver (a) and one even-parity receiver (b).
// Frames are queued as expected results when sent; a negedge process matches rx_done pulses
// against the queue and checks that outputs hold between pulses.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int BIT0 = 8680;    // 434 clocks of 20 at 115200
  localparam int BIT4 = 104160;  // 5208 clocks of 20 at 9600

  typedef struct packed {
    logic       k;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       sysclk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] baud_set = 3'd0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] data_w [2];
  logic       done_w [2];
  logic       perr_w [2];
  logic       ferr_w [2];

  exp_t       exp_q[$];
  logic [7:0] last_d [2];
  logic       last_pe [2];
  logic       last_fe [2];
  int         done_cnt [2];
  int         errors = 0;
  int         checks = 0;

  always #10 sysclk = ~sysclk;

  uart_rx_param dut_a (
    .sysclk(sysclk), .rst(rst), .Baud_set(baud_set), .uart_rx(rx_a),
    .Data(data_w[0]), .rx_done(done_w[0]), .parity_err(perr_w[0]), .frame_err(ferr_w[0])
  );

  uart_rx_param #(.PARITY(PAR_EVEN)) dut_b (
    .sysclk(sysclk), .rst(rst), .Baud_set(baud_set), .uart_rx(rx_b),
    .Data(data_w[1]), .rx_done(done_w[1]), .parity_err(perr_w[1]), .frame_err(ferr_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_line(input int k, input logic v);
    if (k == 0) rx_a = v;
    else        rx_b = v;
  endtask

  // Drive one frame LSB first; the expected result is derived from what goes on the wire.
  task automatic send_frame(input int k, input logic [7:0] d, input logic par_bit,
                            input logic stop_bit, input int bit_ns);
    exp_t e;
    e.k  = 1'(k);
    e.d  = d;
    // Receiver b uses even parity: the parity bit must equal the XOR of the data bits.
    e.pe = (k == 1) ? (par_bit != (^d)) : 1'b0;
    e.fe = ~stop_bit;
    exp_q.push_back(e);
    set_line(k, 1'b0);
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      set_line(k, d[i]);
      #(bit_ns);
    end
    if (k == 1) begin
      set_line(k, par_bit);
      #(bit_ns);
    end
    set_line(k, stop_bit);
    #(bit_ns);
    set_line(k, 1'b1);
  endtask

  // Scoreboard: every rx_done must match the oldest queued frame; outputs hold otherwise.
  always @(negedge sysclk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        last_d[k]  = 8'h00;
        last_pe[k] = 1'b0;
        last_fe[k] = 1'b0;
      end else if (done_w[k]) begin
        logic match;
        exp_t e;
        done_cnt[k]++;
        match = (exp_q.size() != 0) && (exp_q[0].k == 1'(k));
        chk("rx_done_expected", 32'(match), 32'd1);
        if (match) begin
          e = exp_q.pop_front();
          chk("done_data", 32'(data_w[k]), 32'(e.d));
          chk("done_parity_err", 32'(perr_w[k]), 32'(e.pe));
          chk("done_frame_err", 32'(ferr_w[k]), 32'(e.fe));
          last_d[k]  = e.d;
          last_pe[k] = e.pe;
          last_fe[k] = e.fe;
        end
      end else begin
        chk("hold_data", 32'(data_w[k]), 32'(last_d[k]));
        chk("hold_parity_err", 32'(perr_w[k]), 32'(last_pe[k]));
        chk("hold_frame_err", 32'(ferr_w[k]), 32'(last_fe[k]));
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic [2:0] pd;
    int         k;
    int         base;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    last_d[0] = 8'h00; last_d[1] = 8'h00;
    last_pe[0] = 1'b0; last_pe[1] = 1'b0;
    last_fe[0] = 1'b0; last_fe[1] = 1'b0;

    // Reset state
    repeat (5) @(negedge sysclk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_data", 32'(data_w[i]), 32'h0);
      chk("reset_rx_done", 32'(done_w[i]), 32'h0);
      chk("reset_parity_err", 32'(perr_w[i]), 32'h0);
      chk("reset_frame_err", 32'(ferr_w[i]), 32'h0);
    end
    chk("reset_state", 32'(dut_a.state_q), 32'(ST_IDLE));
    rst = 1'b1;
    repeat (10) @(negedge sysclk);

    // Single frame, then a back-to-back frame 100 ns after the stop bit
    send_frame(0, 8'hAB, 1'b0, 1'b1, BIT0);
    chk("ab_data", 32'(data_w[0]), 32'hAB);
    chk("ab_pulses", 32'(done_cnt[0]), 32'd1);
    chk("ab_parity_err", 32'(perr_w[0]), 32'd0);
    chk("ab_frame_err", 32'(ferr_w[0]), 32'd0);
    #100;
    send_frame(0, 8'hCD, 1'b0, 1'b1, BIT0);
    chk("cd_data", 32'(data_w[0]), 32'hCD);
    chk("b2b_pulses", 32'(done_cnt[0]), 32'd2);

    // Short low glitch: start rejected, nothing delivered
    repeat (20) @(negedge sysclk);
    rx_a = 1'b0;
    #2000;
    rx_a = 1'b1;
    #10000;
    chk("glitch_pulses", 32'(done_cnt[0]), 32'd2);
    chk("glitch_state", 32'(dut_a.state_q), 32'(ST_IDLE));
    chk("glitch_data", 32'(data_w[0]), 32'hCD);

    // Framing error, then a clean frame clears it
    send_frame(0, 8'h55, 1'b0, 1'b0, BIT0);
    chk("ferr_flag", 32'(ferr_w[0]), 32'd1);
    chk("ferr_data", 32'(data_w[0]), 32'h55);
    #(20 * $urandom_range(5, 50));
    send_frame(0, 8'h12, 1'b0, 1'b1, BIT0);
    chk("ferr_cleared", 32'(ferr_w[0]), 32'd0);
    chk("data_12", 32'(data_w[0]), 32'h12);

    // Even parity on receiver b: 0x07 has three ones, so the parity bit must be 1
    send_frame(1, 8'h07, 1'b0, 1'b1, BIT0);
    chk("par_bad_flag", 32'(perr_w[1]), 32'd1);
    chk("par_bad_data", 32'(data_w[1]), 32'h07);
    #(20 * $urandom_range(5, 50));
    send_frame(1, 8'h07, 1'b1, 1'b1, BIT0);
    chk("par_good_flag", 32'(perr_w[1]), 32'd0);

    // Random frame on a random receiver
    k = int'($urandom_range(0, 1));
    d = 8'($urandom);
    #(20 * $urandom_range(5, 50));
    send_frame(k, d, 1'($urandom), 1'($urandom_range(0, 3) != 0), BIT0);
    chk("rand_data", 32'(data_w[k]), 32'(d));

    // Reset in the middle of the data bits: frame abandoned, Data cleared
    #(20 * $urandom_range(5, 50));
    base = done_cnt[0];
    pd = 3'($urandom);
    rx_a = 1'b0;
    #(BIT0);
    for (int i = 0; i < 3; i++) begin
      rx_a = pd[i];
      #(BIT0);
    end
    rx_a = 1'b1;
    #(BIT0 / 2);
    rst = 1'b0;
    #200;
    chk("midreset_data", 32'(data_w[0]), 32'h0);
    rst = 1'b1;
    #(2 * BIT0);
    chk("midreset_no_done", 32'(done_cnt[0]), 32'(base));
    send_frame(0, 8'h9A, 1'b0, 1'b1, BIT0);
    chk("after_reset_data", 32'(data_w[0]), 32'h9A);

    // 9600 baud; Baud_set changes mid-frame and must not disturb it
    baud_set = 3'd4;
    #(20 * $urandom_range(5, 50));
    fork
      send_frame(0, 8'h3C, 1'b0, 1'b1, BIT4);
      begin
        #(2 * BIT4);
        baud_set = 3'd1;
      end
    join
    chk("slow_data", 32'(data_w[0]), 32'h3C);
    baud_set = 3'd0;

    #(BIT0);
    chk("all_frames_delivered", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
